// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite controller: fetches one bitmap row per visible sprite
// during horizontal blank into shadow buffers, swaps them into the active
// buffers at line start, and renders a prioritised, X-mirrored pixel stream.
module sprite_line_scheduler #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter logic [8:0]  FETCH_HPOS  = 9'd256,
  parameter logic [8:0]  LOAD_HPOS   = 9'd0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [8:0]               hpos,
  input  logic [8:0]               vpos,
  input  logic                     display_on,
  input  logic [NUM_SPRITES-1:0]   sprite_en,
  input  logic [9*NUM_SPRITES-1:0] sprite_x,
  input  logic [9*NUM_SPRITES-1:0] sprite_y,
  output logic                     rom_req,
  output logic [5:0]               rom_addr,
  input  logic                     rom_ack,
  input  logic [7:0]               rom_data,
  output logic                     gfx,
  output logic [1:0]               gfx_slot,
  output logic                     busy
);

  localparam logic [1:0] LAST_SLOT = 2'(NUM_SPRITES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REQ,
    STORE,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0] slot, slot_nxt;
  logic [3:0] row, row_nxt;

  logic       load_now;
  logic       fetch_start;
  logic       store_en;

  logic [8:0] cur_y;
  logic       cur_en;
  logic [8:0] dy;

  logic [7:0]             shadow_bits  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] shadow_valid;
  logic [7:0]             load_bits    [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] load_valid;
  logic [7:0]             active_bits  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] active_valid;

  logic [3:0]             xofs         [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] drawing;
  logic [2:0]             bit_idx      [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] pix;

  logic       hit;
  logic [1:0] win;

  assign load_now = (hpos == LOAD_HPOS);

  // Select enable and top edge of the slot currently being checked.
  always_comb begin
    cur_y  = '0;
    cur_en = 1'b0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (slot == 2'(i)) begin
        cur_y  = sprite_y[9*i +: 9];
        cur_en = sprite_en[i];
      end
    end
  end

  // Row offset of the next line (vpos + 1) within the sprite, modulo 512.
  assign dy = vpos + 9'd1 - cur_y;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      slot  <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
      row   <= row_nxt;
    end
  end

  // FSM next-state: walk slots, request visible rows, abort on line load.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    row_nxt   = row;
    store_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (hpos == FETCH_HPOS) begin
          state_nxt = CHECK;
          slot_nxt  = '0;
        end
      end
      CHECK: begin
        if (cur_en && (dy < 9'd16)) begin
          row_nxt   = dy[3:0];
          state_nxt = REQ;
        end else if (slot == LAST_SLOT) begin
          state_nxt = DONE;
        end else begin
          slot_nxt = slot + 2'd1;
        end
      end
      REQ: begin
        if (rom_ack) begin
          store_en  = 1'b1;
          state_nxt = STORE;
        end
      end
      STORE: begin
        if (slot == LAST_SLOT) begin
          state_nxt = DONE;
        end else begin
          slot_nxt  = slot + 2'd1;
          state_nxt = CHECK;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Line load wins over any fetch still in flight; store_en is left intact
    // so an ack landing on the load cycle still reaches the active buffer.
    if (load_now) begin
      state_nxt = IDLE;
    end
  end

  assign fetch_start = (state == IDLE) && (state_nxt == CHECK);

  // ROM handshake outputs derive from the registered state.
  always_comb begin
    rom_req  = (state == REQ);
    rom_addr = '0;
    if (state == REQ) begin
      rom_addr = {slot, row};
    end
  end

  assign busy = (state != IDLE);

  // Shadow buffers: cleared at fetch start, written on each ROM ack.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_valid <= '0;
    end else if (fetch_start) begin
      shadow_valid <= '0;
    end else if (store_en) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        if (slot == 2'(i)) begin
          shadow_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Shadow bitmap storage; validity is tracked separately.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (store_en && (slot == 2'(i))) begin
        shadow_bits[i] <= rom_data;
      end
    end
  end

  // Shadow contents as they will be after this cycle's store, for the load.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      load_bits[i]  = shadow_bits[i];
      load_valid[i] = shadow_valid[i];
      if (store_en && (slot == 2'(i))) begin
        load_bits[i]  = rom_data;
        load_valid[i] = 1'b1;
      end
    end
  end

  // Active buffers: take the shadow copy at line start, hold otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      active_valid <= '0;
    end else if (load_now) begin
      active_valid <= load_valid;
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        active_bits[i] <= load_bits[i];
      end
    end
  end

  // Per-slot X counters; drawing stays set through the xofs == 0 pixel.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (!reset) begin
        xofs[i]    <= '0;
        drawing[i] <= 1'b0;
      end else if (hpos == sprite_x[9*i +: 9]) begin
        xofs[i]    <= 4'd15;
        drawing[i] <= 1'b1;
      end else if (xofs[i] != 4'd0) begin
        xofs[i] <= xofs[i] - 4'd1;
      end else begin
        drawing[i] <= 1'b0;
      end
    end
  end

  // Mirrored bit index: 15 - xofs for the upper half equals ~xofs[2:0].
  always_comb begin
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      bit_idx[i] = xofs[i][3] ? ~xofs[i][2:0] : xofs[i][2:0];
      pix[i]     = active_valid[i] & drawing[i] & active_bits[i][bit_idx[i]];
    end
  end

  // Lowest-numbered slot with a set pixel wins.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (pix[i] && !hit) begin
        hit = 1'b1;
        win = 2'(i);
      end
    end
  end

  // Registered pixel output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gfx      <= 1'b0;
      gfx_slot <= '0;
    end else begin
      gfx      <= display_on & hit;
      gfx_slot <= win;
    end
  end

endmodule
